// File: rtl/ppu_mode_scheduler.sv
// PPU scanline/frame sequencer: walks each line through OAM scan, pixel
// transfer and HBlank, runs VBlank for the trailing lines, and derives the
// STAT mode bits, interrupt pulses and CPU-access locks.
module ppu_mode_scheduler #(
    parameter int unsigned DOTS_PER_LINE = 456,
    parameter int unsigned OAM_DOTS      = 80,
    parameter int unsigned VISIBLE_LINES = 144,
    parameter int unsigned TOTAL_LINES   = 154
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dot_en,
    input  logic [7:0] LCDC,
    input  logic [3:0] STAT_EN,
    input  logic [7:0] LYC,
    input  logic       mode3_done,
    output logic       mode3_start,
    output logic       oam_scan_start,
    output logic [7:0] LY,
    output logic [8:0] dot_count,
    output logic [1:0] mode,
    output logic       lyc_match,
    output logic       vblank_irq,
    output logic       stat_irq,
    output logic       vram_locked,
    output logic       oam_locked,
    output logic       mode3_overrun,
    output logic       frame_start
);

    localparam logic [8:0] LP_DOT_LAST = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] LP_OAM_END  = 9'(OAM_DOTS);
    localparam logic [7:0] LP_LY_LAST  = 8'(TOTAL_LINES - 1);
    localparam logic [7:0] LP_VIS      = 8'(VISIBLE_LINES);

    typedef enum logic [2:0] {
        ST_OFF,
        ST_OAM,
        ST_XFER,
        ST_HBLANK,
        ST_VBLANK
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_ly, w_ly_nxt, w_ly_inc;
    logic [8:0] r_dot, w_dot_nxt;
    logic       r_oam_start, w_oam_start;
    logic       r_frame_start, w_frame_start;
    logic       r_m3_start, w_m3_start;
    logic       r_vblank, w_vblank;
    logic       r_overrun, w_overrun;
    logic       r_lyc;
    logic       r_stat_line, w_stat_line;
    logic [1:0] w_mode;
    logic       w_wrap;
    logic       w_unused_lcdc;

    assign w_unused_lcdc = &{1'b0, LCDC[6:0]};

    assign w_wrap   = (r_dot == LP_DOT_LAST);
    assign w_ly_inc = (r_ly == LP_LY_LAST) ? '0 : r_ly + 8'd1;

    // Next-state, counter and pulse decode; disable overrides everything.
    // A line wrap wins over a same-tick mode3_done so the new line still
    // starts in OAM; the done only suppresses the overrun pulse.
    always_comb begin
        w_state_nxt   = r_state;
        w_ly_nxt      = r_ly;
        w_dot_nxt     = r_dot;
        w_oam_start   = 1'b0;
        w_frame_start = 1'b0;
        w_m3_start    = 1'b0;
        w_vblank      = 1'b0;
        w_overrun     = 1'b0;
        if (!LCDC[7]) begin
            w_state_nxt = ST_OFF;
            w_ly_nxt    = '0;
            w_dot_nxt   = '0;
        end else if (r_state == ST_OFF) begin
            w_state_nxt   = ST_OAM;
            w_ly_nxt      = '0;
            w_dot_nxt     = '0;
            w_oam_start   = 1'b1;
            w_frame_start = 1'b1;
        end else begin
            if (r_state == ST_XFER && mode3_done) begin
                w_state_nxt = ST_HBLANK;
            end
            if (dot_en) begin
                if (w_wrap) begin
                    w_dot_nxt = '0;
                    w_ly_nxt  = w_ly_inc;
                    w_overrun = (r_state == ST_XFER) && !mode3_done;
                    if (w_ly_inc < LP_VIS) begin
                        w_state_nxt   = ST_OAM;
                        w_oam_start   = 1'b1;
                        w_frame_start = (w_ly_inc == '0);
                    end else begin
                        w_state_nxt = ST_VBLANK;
                        w_vblank    = (w_ly_inc == LP_VIS);
                    end
                end else begin
                    w_dot_nxt = r_dot + 9'd1;
                    if (r_state == ST_OAM && w_dot_nxt == LP_OAM_END) begin
                        w_state_nxt = ST_XFER;
                        w_m3_start  = 1'b1;
                    end
                end
            end
        end
    end

    // STAT mode decode and the combined STAT interrupt line.
    always_comb begin
        w_mode = 2'd0;
        case (r_state)
            ST_OAM:    w_mode = 2'd2;
            ST_XFER:   w_mode = 2'd3;
            ST_VBLANK: w_mode = 2'd1;
            default:   w_mode = 2'd0;
        endcase
        w_stat_line = (r_state != ST_OFF) &&
                      ((STAT_EN[3] && r_lyc) ||
                       (STAT_EN[2] && w_mode == 2'd2) ||
                       (STAT_EN[1] && w_mode == 2'd1) ||
                       (STAT_EN[0] && w_mode == 2'd0));
    end

    // State, counters, one-clock pulses, LY compare and STAT edge history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_OFF;
            r_ly          <= '0;
            r_dot         <= '0;
            r_oam_start   <= 1'b0;
            r_frame_start <= 1'b0;
            r_m3_start    <= 1'b0;
            r_vblank      <= 1'b0;
            r_overrun     <= 1'b0;
            r_lyc         <= 1'b0;
            r_stat_line   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_ly          <= w_ly_nxt;
            r_dot         <= w_dot_nxt;
            r_oam_start   <= w_oam_start;
            r_frame_start <= w_frame_start;
            r_m3_start    <= w_m3_start;
            r_vblank      <= w_vblank;
            r_overrun     <= w_overrun;
            r_lyc         <= (r_ly == LYC);
            r_stat_line   <= LCDC[7] ? w_stat_line : 1'b0;
        end
    end

    assign mode           = w_mode;
    assign LY             = r_ly;
    assign dot_count      = r_dot;
    assign lyc_match      = r_lyc;
    assign mode3_start    = r_m3_start;
    assign oam_scan_start = r_oam_start;
    assign frame_start    = r_frame_start;
    assign vblank_irq     = r_vblank;
    assign mode3_overrun  = r_overrun;
    assign stat_irq       = w_stat_line && !r_stat_line;
    assign vram_locked    = (r_state == ST_XFER);
    assign oam_locked     = (r_state == ST_XFER) || (r_state == ST_OAM);

endmodule

// File: doc/ppu_mode_scheduler.md
Name: ppu_mode_scheduler

Overview:
Per-dot scanline/frame sequencer for the PPU. It generates LY and the dot position, walks each line through OAM scan (mode 2), pixel transfer (mode 3) and HBlank (mode 0), and runs VBlank (mode 1) for lines 144-153. It launches the mode 3 pixel pipeline with a start pulse and waits for its done pulse. It also drives the STAT mode bits, the VBlank and STAT interrupt pulses, and the VRAM/OAM CPU-access lock signals used by the bus arbiter.

Parameters:
DOTS_PER_LINE, 456, dots per scanline (dot_count wraps at DOTS_PER_LINE-1)
OAM_DOTS, 80, length of mode 2 in dots
VISIBLE_LINES, 144, first VBlank line index
TOTAL_LINES, 154, lines per frame (LY wraps at TOTAL_LINES-1)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
dot_en  in  1  one-cycle dot tick; all counting advances only on cycles with dot_en=1
LCDC  in  8  LCD control; bit7 = LCD enable
STAT_EN  in  4  STAT interrupt enables {LYC(bit6), mode2(bit5), mode1(bit4), mode0(bit3)}
LYC  in  8  LY compare value
mode3_done  in  1  one-cycle done pulse from the mode 3 pixel pipeline
mode3_start  out  1  one-cycle start pulse to the mode 3 pixel pipeline
oam_scan_start  out  1  one-cycle pulse at the start of mode 2
LY  out  8  current line, 0..153
dot_count  out  9  current dot, 0..455
mode  out  2  STAT mode: 0=HBlank, 1=VBlank, 2=OAM, 3=transfer
lyc_match  out  1  LY==LYC, registered
vblank_irq  out  1  one-cycle pulse on entering line 144
stat_irq  out  1  one-cycle pulse on a rising edge of the STAT line
vram_locked  out  1  high while mode==3
oam_locked  out  1  high while mode==2 or mode==3
mode3_overrun  out  1  one-cycle pulse when mode 3 is force-terminated
frame_start  out  1  one-cycle pulse when LY returns to 0 at dot 0

Behaviour:
- Reset: clk is the only clock. rst_n is asynchronous and active-low. While rst_n=0, every output is 0: LY=0, dot_count=0, mode=0, all pulses 0, both locks 0, lyc_match=0. The internal STAT-line register is 0 and the FSM is in OFF.
- All pulse outputs are exactly 1 clk wide, regardless of the dot_en duty cycle.
- FSM states: OFF, OAM, XFER, HBLANK, VBLANK.
- OFF:
  - Counters are held at 0, mode=0, locks=0.
  - When LCDC[7]=1, go to OAM on the next clk with LY=0 and dot=0, and pulse oam_scan_start and frame_start in that same cycle.
- Counting (only when dot_en=1):
  - dot_count increments by 1.
  - At dot_count==DOTS_PER_LINE-1, dot_count goes to 0 and LY increments. LY==TOTAL_LINES-1 wraps to 0.
  - LY and dot_count always update in the same clk.
- Line start (dot wraps to 0):
  - New LY < VISIBLE_LINES: go to OAM and pulse oam_scan_start. If new LY==0, also pulse frame_start.
  - New LY == VISIBLE_LINES: go to VBLANK and pulse vblank_irq.
  - New LY > VISIBLE_LINES: stay in VBLANK.
- OAM: mode=2. On the dot_en tick where dot_count advances to OAM_DOTS, go to XFER and pulse mode3_start in the same clk.
- XFER: mode=3.
  - mode3_done=1 → HBLANK on the next clk.
  - If dot_count is DOTS_PER_LINE-1 with dot_en=1 and no mode3_done, force the line-start transition and pulse mode3_overrun.
  - If mode3_done arrives in that same cycle, it counts as a normal completion: no overrun.
- HBLANK: mode=0 until the line wrap.
- VBLANK: mode=1 until LY wraps to 0, then go to OAM.
- mode3_done outside XFER is ignored.
- lyc_match = (LY==LYC). It is registered from the updated LY, so it is valid 1 clk after LY changes; it also tracks LYC changes with 1 clk latency.
- STAT line = (STAT_EN[3]&lyc_match) | (STAT_EN[2]&mode==2) | (STAT_EN[1]&mode==1) | (STAT_EN[0]&mode==0).
  - stat_irq pulses only on a 0→1 transition of the STAT line (STAT blocking).
  - While the line stays high across a source change, there is no new pulse.
- LCDC[7] falling (any state, synchronous): go to OFF on the next clk.
  - LY, dot_count and mode become 0; locks drop; any pending mode 3 is abandoned without mode3_overrun.
  - The STAT-line register clears, so stat_irq does not fire on the disable.
- Asynchronous reset mid-line behaves the same as LCD disable, but takes effect immediately.

Test Plan:
- Enable LCD, dot_en=1 every clk, mode3_done pulsed 172 dots after mode3_start:
  - oam_scan_start at dot 0; mode3_start when dot 80; mode=0 from dot 252.
  - Line wrap after dot 455; LY increments.
- Run a full frame: vblank_irq once when LY becomes 144, mode=1 through LY 153, frame_start once when LY=0; 70224 dot ticks per frame.
- Never assert mode3_done: mode3_overrun pulses at dot 455 of each visible line; the next line starts in mode 2 normally; vram_locked is high dots 80-455.
- STAT_EN=4'b1001, LYC=0: a single stat_irq at LY=0 dot 0, with no pulse at HBlank entry on that line because the line is still high. LYC=0x05: a pulse at LY=5.
- Drop LCDC[7] in mid-XFER at LY=37 dot 200: next clk LY=0, dot_count=0, mode=0, locks 0, and no overrun or stat_irq.
- dot_en every 4th clk: all counter/mode timing scales by 4, and every pulse stays 1 clk wide. Assert rst_n=0 mid-frame: outputs go to 0 immediately.
